// File: rtl/usbf_tx_fetch.sv
`default_nettype none
// ============================================================================
// Module   : usbf_tx_fetch
// Brief    : Transmit byte fetcher for the USB packet assembler. Reads a
//            payload of up to 2047 bytes from 32-bit buffer memory through a
//            two-word prefetch buffer, presents it one byte at a time and
//            drives the assembler's send_data / send_zero_length framing.
// Revision : 1.0 - initial release
// ============================================================================
module usbf_tx_fetch #(
    parameter int SSRAM_HADR = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SSRAM_HADR+2:0]   start_adr,
    input  logic [10:0]             size,
    input  logic                    abort,
    output logic                    mreq,
    input  logic                    mack,
    output logic [SSRAM_HADR:0]     madr,
    input  logic [31:0]             mdin,
    output logic [7:0]              tx_data_st,
    input  logic                    rd_next,
    output logic                    send_data,
    output logic                    send_zero_length,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZL1  = 2'd1,
        ZL2  = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [SSRAM_HADR:0] MADR_INC = 1;

    state_t         state;

    // Two-word prefetch buffer: head holds the word being streamed.
    logic [31:0]    buf_head;
    logic [31:0]    buf_tail;
    logic [1:0]     buf_cnt;

    logic [1:0]     byte_ptr;
    logic [10:0]    bytes_left;
    logic [12:0]    words_left;

    // A word has been pushed in this transfer; send_data follows one edge later.
    logic           pushed_any;

    logic           in_run;
    logic           buf_empty;
    logic           consume;
    logic           last_byte;
    logic           pop;
    logic           push;
    logic           start_idle;
    logic           start_run;
    logic [12:0]    words_sum;

    // Handshake decode shared by the fetch, buffer and stream logic.
    always_comb begin
        in_run     = (state == RUN);
        buf_empty  = (buf_cnt == 2'd0);
        consume    = in_run & rd_next;
        last_byte  = consume & (bytes_left == 11'd1);
        // The head word leaves on a 3->0 pointer wrap or with the final byte.
        pop        = consume & ~buf_empty & ((byte_ptr == 2'd3) | (bytes_left == 11'd1));
        // A word leaving this cycle frees its slot, so a full buffer can still request.
        mreq       = in_run & (words_left != 13'd0) & ((buf_cnt != 2'd2) | pop);
        push       = mreq & mack;
        start_idle = (state == IDLE) & start & ~abort;
        start_run  = start_idle & (size != 11'd0);
        // Words touched = ceil((offset + size) / 4), kept at 13 bits to avoid overflow.
        words_sum  = {11'd0, start_adr[1:0]} + {2'd0, size} + 13'd3;
    end

    assign busy = (state != IDLE);

    // Byte select from the head word; registers only, no path from rd_next.
    always_comb begin
        tx_data_st = 8'd0;
        if (!buf_empty) begin
            case (byte_ptr)
                2'd0:    tx_data_st = buf_head[7:0];
                2'd1:    tx_data_st = buf_head[15:8];
                2'd2:    tx_data_st = buf_head[23:16];
                default: tx_data_st = buf_head[31:24];
            endcase
        end
    end

    // Fetch engine: memory address and count of words still to be read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            madr       <= '0;
            words_left <= '0;
        end else if (abort) begin
            madr       <= '0;
            words_left <= '0;
        end else if (start_run) begin
            madr       <= start_adr[SSRAM_HADR+2:2];
            words_left <= {2'd0, words_sum[12:2]};
        end else begin
            if (push) begin
                madr <= madr + MADR_INC;
            end
            if (last_byte) begin
                words_left <= '0;
            end else if (push) begin
                words_left <= words_left - 13'd1;
            end
        end
    end

    // Prefetch buffer: push at the tail, pop from the head, flush on end or abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_head <= '0;
            buf_tail <= '0;
            buf_cnt  <= 2'd0;
        end else if (abort | last_byte) begin
            buf_cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf_head <= mdin;
                    end else begin
                        buf_tail <= mdin;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    buf_cnt  <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (buf_cnt == 2'd1) begin
                        buf_head <= mdin;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= mdin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stream engine: byte pointer, remaining byte count and sticky underrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_ptr   <= 2'd0;
            bytes_left <= 11'd0;
            underrun   <= 1'b0;
        end else if (abort) begin
            byte_ptr   <= 2'd0;
            bytes_left <= 11'd0;
        end else if (start_idle) begin
            underrun <= 1'b0;
            if (size != 11'd0) begin
                byte_ptr   <= start_adr[1:0];
                bytes_left <= size;
            end
        end else if (consume) begin
            // A starved read still advances; the assembler sees a zero byte.
            if (buf_empty) begin
                underrun <= 1'b1;
            end
            if (last_byte) begin
                byte_ptr   <= 2'd0;
                bytes_left <= 11'd0;
            end else begin
                byte_ptr   <= byte_ptr + 2'd1;
                bytes_left <= bytes_left - 11'd1;
            end
        end
    end

    // Transfer sequencing and the assembler framing flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            send_data        <= 1'b0;
            send_zero_length <= 1'b0;
            done             <= 1'b0;
            pushed_any       <= 1'b0;
        end else if (abort) begin
            state            <= IDLE;
            send_data        <= 1'b0;
            send_zero_length <= 1'b0;
            done             <= 1'b0;
            pushed_any       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (size == 11'd0) begin
                            state            <= ZL1;
                            send_zero_length <= 1'b1;
                        end else begin
                            state      <= RUN;
                            pushed_any <= 1'b0;
                        end
                    end
                end
                ZL1: begin
                    state     <= ZL2;
                    send_data <= 1'b1;
                end
                ZL2: begin
                    state            <= IDLE;
                    send_data        <= 1'b0;
                    send_zero_length <= 1'b0;
                    done             <= 1'b1;
                end
                RUN: begin
                    if (last_byte) begin
                        // Low send_data right after the final byte lets the assembler enter CRC1.
                        state     <= IDLE;
                        send_data <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        if (pushed_any) begin
                            send_data <= 1'b1;
                        end
                        if (push) begin
                            pushed_any <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/usbf_tx_fetch.md
# usbf_tx_fetch

Transmit-side byte fetcher that sits directly upstream of the USB packet assembler. On a start pulse it reads a payload of up to 2047 bytes from 32-bit buffer memory, keeps a two-word prefetch buffer, and presents one byte at a time on `tx_data_st`, advancing on the assembler's `rd_next`. It also generates the assembler's `send_data` / `send_zero_length` framing: DATA0/1 PID, payload, CRC16.

## Interface
- `SSRAM_HADR`, 14: buffer memory word-address MSB; word address is `SSRAM_HADR+1` bits.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begin a transfer. Ignored unless in IDLE.
- `start_adr`  in  `SSRAM_HADR+3`  byte address of the first payload byte; `[1:0]` is the byte offset, upper bits are the word address.
- `size`  in  11  payload byte count, 0..2047. Sampled with `start`.
- `abort`  in  1  terminate the current transfer.
- `mreq`  out  1  memory read request.
- `mack`  in  1  memory acknowledge; `mdin` is valid in the same cycle.
- `madr`  out  `SSRAM_HADR+1`  memory word address.
- `mdin`  in  32  memory read data; byte 0 is `[7:0]`.
- `tx_data_st`  out  8  current payload byte, to the packet assembler.
- `rd_next`  in  1  assembler consumed `tx_data_st`.
- `send_data`  out  1  to the assembler.
- `send_zero_length`  out  1  to the assembler.
- `busy`  out  1  not IDLE.
- `done`  out  1  one-cycle pulse; transfer completed normally.
- `underrun`  out  1  sticky; cleared by `start`.

## Operation
- **States:** IDLE, ZL1, ZL2, RUN.
- **Reset values:** `mreq`=0, `madr`=0, `tx_data_st`=0, `send_data`=0, `send_zero_length`=0, `busy`=0, `done`=0, `underrun`=0. Buffer is empty, all counters are 0, and the FSM is in IDLE.
- **IDLE + start, size=0:** go to ZL1; `send_zero_length`=1.
  - ZL1 → ZL2: `send_zero_length`=1, `send_data`=1.
  - ZL2 → IDLE: both outputs low; `done` pulses on that edge.
  - No memory access is made.
- **IDLE + start, size>0:** go to RUN.
  - Latch `words_left` = (offset+size+3)>>2, computed at 13-bit width.
  - Latch `bytes_left` = size and byte pointer = offset.
  - Set `madr` = `start_adr[SSRAM_HADR+2:2]`.
- **RUN, fetch engine:**
  - `mreq` is high whenever `words_left`>0 and fewer than 2 words are buffered, counting a word being popped this cycle as free.
  - On `mreq`&`mack`: push `mdin`, increment `madr` (wraps at all-ones), decrement `words_left`.
  - `mack` is ignored when `mreq`=0.
- **RUN, stream engine:**
  - `tx_data_st` = byte[pointer] of the head word, or 0 when the buffer is empty.
  - On `rd_next`: pointer+1 and `bytes_left`−1. When the pointer wraps 3→0, pop the head word.
  - On the final byte, pop the head word regardless of pointer.
- **send_data:** set on the edge after the first word is pushed. Cleared on the edge where `rd_next` consumes the last byte. On that same edge the FSM returns to IDLE, `done` pulses, and the buffer is flushed.
- **Underrun:** `rd_next` while the buffer is empty sets `underrun`. `bytes_left` still decrements, the pointer still advances, and the data is 0.
- **Simultaneous push and pop:** both occur in the same cycle; occupancy is unchanged.
- **abort (any state):**
  - Next edge: IDLE, all outputs to reset values except `underrun`, buffer flushed, no `done`.
  - A `mack` arriving in that cycle is dropped.
  - `abort` has priority over `start`.
- **Reset mid-operation:** immediate return to reset values; no partial outputs.

## Timing
- `start` sampled at edge 0. From edge 0: `busy`=1 and `mreq`=1 with the first `madr`.
- `mack` at edge k: word pushed. From edge k+1: `send_data`=1 and `tx_data_st` is valid.
- With zero-wait `mack`:
  - `mreq` stays high on consecutive cycles until 2 words are buffered.
  - Sustained throughput is 1 byte/cycle.
  - First-byte latency is 2 cycles.
- `tx_data_st` updates the cycle after `rd_next`; it is registered-path or mux from registers only, with no combinational path from `rd_next`.
- `send_data` is low in the cycle after the final `rd_next`, as the assembler requires to enter CRC1.
- `done` is high for exactly one cycle.

## Test plan
- **Aligned payload:** start, adr=0x100, size=5, `mack` immediate, `rd_next` every cycle from the first valid byte, words 0x44332211 and 0x88776655.
  - `mreq` at 0x40, then 0x41, exactly 2 requests.
  - Bytes 11 22 33 44 55.
  - `send_data` drops after the 5th `rd_next`; `done` pulses once.
- **Unaligned payload:** adr=0x103, size=2, same words.
  - Bytes 44, 55; 2 requests.
- **Zero-length:** size=0.
  - `send_zero_length` high 2 cycles; `send_data` high only in the 2nd.
  - No `mreq`; `done` 3 cycles after start.
- **Underrun:** size=8, `mack` delayed 5 cycles, `rd_next` every cycle.
  - `underrun`=1 and `tx_data_st`=0 for the starved bytes.
  - `done` still asserts after 8 `rd_next`.
  - Next `start` clears `underrun`.
- **Abort:** size=100; assert `abort` while `mreq`=1 and `mack` arrives in the same cycle.
  - Next cycle: `mreq`=0, `send_data`=0, `busy`=0, no `done`.
  - Following start, adr=0x200, size=1: fresh request at 0x80.
- **Reset mid-RUN:** pull `rst` low mid-RUN.
  - All outputs reach reset values asynchronously.
  - After release, `start` behaves as in the aligned-payload case.
